// File: rtl/mac_divider.sv
// mac_divider: sequential signed restoring divider for the MAC datapath.
// Divides a DW-bit two's-complement dividend by a VW-bit two's-complement
// divisor. The quotient is truncated toward zero and the remainder takes the
// sign of the dividend. One magnitude bit is resolved per cycle, MSB first,
// and a final FIX cycle applies the signs and the special cases.
module mac_divider #(
  parameter int DW = 10,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          dbz,
  output logic          ovf
);

  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Control state
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;

  // Datapath: partial remainder, dividend magnitude shifting into quotient
  // magnitude, and the captured divisor magnitude.
  logic [VW:0]   p, p_n;
  logic [DW-1:0] dq, dq_n;
  logic [VW-1:0] dv_mag, dv_mag_n;

  // Operation attributes captured at acceptance
  logic neg_q, neg_q_n;
  logic neg_r, neg_r_n;
  logic sel_dbz, sel_dbz_n;
  logic sel_ovf, sel_ovf_n;

  // Next values of the registered outputs
  logic          busy_n, done_n, dbz_n, ovf_n;
  logic [DW-1:0] quotient_n;
  logic [VW-1:0] remainder_n;

  // Restoring step helpers
  logic [VW:0]   p_sh;
  logic [VW+1:0] trial;

  // Operand decode helpers used at acceptance
  logic [DW-1:0] dd_mag;
  logic [VW-1:0] ds_mag;
  logic          ds_zero;
  logic          ovf_case;

  localparam logic [DW-1:0] DD_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic [VW-1:0] DS_M1  = {VW{1'b1}};

  // Operand magnitudes: -2^(DW-1) maps to 2^(DW-1), which still fits DW bits unsigned.
  assign dd_mag   = dividend[DW-1] ? -dividend : dividend;
  assign ds_mag   = divisor[VW-1]  ? -divisor  : divisor;
  assign ds_zero  = (divisor == '0);
  assign ovf_case = (dividend == DD_MIN) && (divisor == DS_M1);

  // One restoring step: shift {p, dq} left and trial-subtract |divisor| one bit wider.
  assign p_sh  = {p[VW-1:0], dq[DW-1]};
  assign trial = {1'b0, p_sh} - {2'b00, dv_mag};

  // Next-state and datapath/output update for the current state.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_n     = state;
    cnt_n       = cnt;
    p_n         = p;
    dq_n        = dq;
    dv_mag_n    = dv_mag;
    neg_q_n     = neg_q;
    neg_r_n     = neg_r;
    sel_dbz_n   = sel_dbz;
    sel_ovf_n   = sel_ovf;
    busy_n      = busy;
    done_n      = 1'b0;
    quotient_n  = quotient;
    remainder_n = remainder;
    dbz_n       = dbz;
    ovf_n       = ovf;

    unique case (state)
      IDLE: begin
        if (start) begin
          busy_n    = 1'b1;
          neg_q_n   = dividend[DW-1] ^ divisor[VW-1];
          neg_r_n   = dividend[DW-1];
          sel_dbz_n = ds_zero;
          sel_ovf_n = ovf_case;
          dq_n      = dd_mag;
          dv_mag_n  = ds_mag;
          p_n       = '0;
          cnt_n     = CW'(DW-1);
          // A zero divisor skips the iterations entirely.
          state_n   = ds_zero ? FIX : CALC;
        end
      end

      CALC: begin
        if (!trial[VW+1]) begin
          p_n  = trial[VW:0];
          dq_n = {dq[DW-2:0], 1'b1};
        end else begin
          p_n  = p_sh;
          dq_n = {dq[DW-2:0], 1'b0};
        end
        if (cnt == '0) begin
          state_n = FIX;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end

      FIX: begin
        busy_n  = 1'b0;
        done_n  = 1'b1;
        dbz_n   = sel_dbz;
        ovf_n   = sel_ovf;
        state_n = IDLE;
        if (sel_dbz) begin
          quotient_n  = '0;
          remainder_n = '0;
        end else begin
          // The overflow case needs no special datapath: magnitude 2^(DW-1)
          // with a positive sign already reads back as the wrapped value.
          quotient_n  = neg_q ? -dq : dq;
          remainder_n = neg_r ? -p[VW-1:0] : p[VW-1:0];
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      p         <= '0;
      dq        <= '0;
      dv_mag    <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      sel_dbz   <= 1'b0;
      sel_ovf   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      p         <= p_n;
      dq        <= dq_n;
      dv_mag    <= dv_mag_n;
      neg_q     <= neg_q_n;
      neg_r     <= neg_r_n;
      sel_dbz   <= sel_dbz_n;
      sel_ovf   <= sel_ovf_n;
      busy      <= busy_n;
      done      <= done_n;
      quotient  <= quotient_n;
      remainder <= remainder_n;
      dbz       <= dbz_n;
      ovf       <= ovf_n;
    end
  end

endmodule

// File: tb/tb_mac_divider.sv
// tb_mac_divider: directed bench for mac_divider. A cycle-level reference
// model derives the outputs from integer division and a simple countdown;
// a compare process checks every output on every falling edge, and each
// directed case also checks hand-computed literal results and latency.
module tb_mac_divider;

  localparam int DW = 10;
  localparam int VW = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          dbz;
  logic          ovf;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  mac_divider #(.DW(DW), .VW(VW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: results from integer division, timing from a countdown
  // of edges remaining until the result edge.
  logic          m_busy = 1'b0;
  logic          m_done = 1'b0;
  logic [DW-1:0] m_q = '0;
  logic [VW-1:0] m_r = '0;
  logic          m_dbz = 1'b0;
  logic          m_ovf = 1'b0;
  logic [DW-1:0] pend_q;
  logic [VW-1:0] pend_r;
  logic          pend_dbz, pend_ovf;
  int            m_left = 0;
  logic          chk_en = 1'b0;

  always @(posedge clk) begin
    int a, b, q, r;
    chk_en = 1'b1;
    m_done = 1'b0;
    if (rst) begin
      m_busy = 1'b0;
      m_q    = '0;
      m_r    = '0;
      m_dbz  = 1'b0;
      m_ovf  = 1'b0;
      m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_q    = pend_q;
        m_r    = pend_r;
        m_dbz  = pend_dbz;
        m_ovf  = pend_ovf;
      end
    end else if (start) begin
      a = $signed(dividend);
      b = $signed(divisor);
      pend_dbz = 1'b0;
      pend_ovf = 1'b0;
      if (b == 0) begin
        pend_dbz = 1'b1;
        q = 0;
        r = 0;
      end else if (a == -(1 << (DW-1)) && b == -1) begin
        pend_ovf = 1'b1;
        q = -(1 << (DW-1));
        r = 0;
      end else begin
        q = a / b;
        r = a % b;
      end
      pend_q = q[DW-1:0];
      pend_r = r[VW-1:0];
      m_busy = 1'b1;
      m_left = (b == 0) ? 1 : DW + 1;
    end
  end

  // Compare process: all outputs, every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",      busy,      m_busy);
      check("done",      done,      m_done);
      check("quotient",  quotient,  m_q);
      check("remainder", remainder, m_r);
      check("dbz",       dbz,       m_dbz);
      check("ovf",       ovf,       m_ovf);
    end
    if (done) done_cnt++;
  end

  // Issue one operation from idle, wait (bounded) for done, then check the
  // hand-computed literals and the number of edges after the accepting edge.
  task automatic do_op(input string name,
                       input logic [DW-1:0] dvd, input logic [VW-1:0] dvs,
                       input logic [DW-1:0] exp_q, input logic [VW-1:0] exp_r,
                       input logic exp_dbz, input logic exp_ovf, input int exp_lat);
    int n;
    @(posedge clk);
    #1;
    start    = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!done && n < 20);
    check({name, " latency"},   n,         exp_lat);
    check({name, " done"},      done,      1'b1);
    check({name, " quotient"},  quotient,  exp_q);
    check({name, " remainder"}, remainder, exp_r);
    check({name, " dbz"},       dbz,       exp_dbz);
    check({name, " ovf"},       ovf,       exp_ovf);
  endtask

  initial begin
    int d0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy",      busy,      1'b0);
    check("reset done",      done,      1'b0);
    check("reset quotient",  quotient,  10'h000);
    check("reset remainder", remainder, 4'h0);
    #1;
    rst = 1'b0;

    // Normal latency is 11 edges after acceptance; divide by zero resolves at
    // the first edge after acceptance.
    do_op("100/7",   10'd100, 4'd7, 10'd14,  4'd2, 1'b0, 1'b0, 11);
    do_op("-100/7",  10'h39C, 4'd7, 10'h3F2, 4'hE, 1'b0, 1'b0, 11);
    do_op("100/-8",  10'd100, 4'h8, 10'h3F4, 4'd4, 1'b0, 1'b0, 11);
    do_op("55/0",    10'd55,  4'd0, 10'd0,   4'd0, 1'b1, 1'b0, 1);
    do_op("9/3",     10'd9,   4'd3, 10'd3,   4'd0, 1'b0, 1'b0, 11);
    do_op("-512/-1", 10'h200, 4'hF, 10'h200, 4'd0, 1'b0, 1'b1, 11);
    do_op("-512/1",  10'h200, 4'd1, 10'h200, 4'd0, 1'b0, 1'b0, 11);
    do_op("-7/-3",   10'h3F9, 4'hD, 10'd2,   4'hF, 1'b0, 1'b0, 11);
    do_op("511/7",   10'd511, 4'd7, 10'd73,  4'd0, 1'b0, 1'b0, 11);

    // Start while busy is ignored and operand changes after acceptance are invisible.
    @(posedge clk);
    #1;
    start    = 1'b1;
    dividend = 10'd30;
    divisor  = 4'd4;
    d0 = done_cnt;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 10'd99;
    divisor  = 4'h9;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("busy-start done count", done_cnt - d0, 1);
    check("busy-start quotient",   quotient,      10'd7);
    check("busy-start remainder",  remainder,     4'd2);
    check("busy-start idle",       busy,          1'b0);

    // Reset mid-operation abandons it: no done pulse, outputs return to zero.
    @(posedge clk);
    #1;
    start    = 1'b1;
    dividend = 10'd100;
    divisor  = 4'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    d0 = done_cnt;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid-reset busy",      busy,      1'b0);
    check("mid-reset quotient",  quotient,  10'd0);
    check("mid-reset remainder", remainder, 4'd0);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("mid-reset no done", done_cnt - d0, 0);

    // 9 is not representable as a 4-bit signed divisor, so 81/3 follows instead.
    do_op("81/3", 10'd81, 4'd3, 10'd27, 4'd0, 1'b0, 1'b0, 11);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
